// File: rtl/tx_resp_sequencer_pkg.sv
// Shared FSM encoding and response-entry type tags for the TX response path.
// No logic; types and helpers only.
// Imported by the sequencer top and its queue.
package tx_resp_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  typedef enum logic {
    RESP_ALU = 1'b0,
    RESP_REG = 1'b1
  } resp_type_e;

  // Width of a down-counter that must hold n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_resp_sequencer_fifo.sv
// resp_fifo: single-clock circular queue of pending response entries.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module resp_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full queue still takes a push then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tx_resp_sequencer.sv
// Queues ALU/register-read responses and serialises them byte-by-byte to a UART.
// Latency: strobe in cycle 0 (idle, empty, not busy) -> tx_d_vld in cycle 3.
// Backpressure: waits on busy per byte; queue overflow or dual strobe pulses drop_err.
module tx_resp_sequencer
  import tx_resp_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ALU_BYTES   = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int LSB_FIRST   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALU_BYTES*DATA_WIDTH-1:0]   alu_out,
  input  logic                              alu_out_valid,
  input  logic [DATA_WIDTH-1:0]             rd_data,
  input  logic                              rd_data_valid,
  input  logic                              busy,
  output logic [DATA_WIDTH-1:0]             tx_p_data,
  output logic                              tx_d_vld,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]  q_count,
  output logic                              drop_err
);

  localparam int ALU_W = ALU_BYTES * DATA_WIDTH;
  localparam int ENT_W = ALU_W + 1;
  localparam int CNT_W = cnt_width(ALU_BYTES);

  tx_state_e             state_q, state_d;
  logic [ALU_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                  tx_d_vld_q, tx_d_vld_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  drop_err_q, drop_err_d;

  logic                  fifo_push;
  logic [ENT_W-1:0]      fifo_push_dat;
  logic                  fifo_pop;
  logic [ENT_W-1:0]      fifo_pop_dat;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_type_e            head_type;
  logic [ALU_W-1:0]      head_payload;
  logic [DATA_WIDTH-1:0] cur_byte;

  // ALU result wins a same-cycle collision; the register byte is zero-extended.
  always_comb begin
    fifo_push     = alu_out_valid || rd_data_valid;
    fifo_push_dat = {RESP_REG, ALU_W'(rd_data)};
    if (alu_out_valid) begin
      fifo_push_dat = {RESP_ALU, alu_out};
    end
  end

  resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (q_count)
  );

  assign head_type    = resp_type_e'(fifo_pop_dat[ALU_W]);
  assign head_payload = fifo_pop_dat[ALU_W-1:0];
  assign cur_byte     = (LSB_FIRST != 0) ? sr_q[DATA_WIDTH-1:0]
                                         : sr_q[ALU_W-1 -: DATA_WIDTH];

  // A discard happens on a dual strobe or on a push into a full queue not being drained.
  always_comb begin
    drop_err_d = (alu_out_valid && rd_data_valid) ||
                 (fifo_push && fifo_full && !fifo_pop);
  end

  // Serialiser FSM: load an entry, hand out one byte per busy handshake.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    byte_cnt_d  = byte_cnt_q;
    tx_d_vld_d  = 1'b0;
    tx_p_data_d = tx_p_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SEND;
          if (head_type == RESP_ALU) begin
            sr_d       = head_payload;
            byte_cnt_d = CNT_W'(ALU_BYTES - 1);
          end else begin
            // MS-first sends from the top byte, so park the single byte there.
            sr_d       = (LSB_FIRST != 0) ? head_payload
                                          : (head_payload << (ALU_W - DATA_WIDTH));
            byte_cnt_d = '0;
          end
        end
      end
      ST_SEND: begin
        if (!busy) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = cur_byte;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          if (byte_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            sr_d       = (LSB_FIRST != 0) ? (sr_q >> DATA_WIDTH) : (sr_q << DATA_WIDTH);
            byte_cnt_d = byte_cnt_q - CNT_W'(1);
            state_d    = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      byte_cnt_q  <= '0;
      tx_d_vld_q  <= 1'b0;
      tx_p_data_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_d_vld_q  <= tx_d_vld_d;
      tx_p_data_q <= tx_p_data_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign tx_d_vld  = tx_d_vld_q;
  assign tx_p_data = tx_p_data_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_tx_resp_sequencer.sv
// Bench for tx_resp_sequencer: directed scenarios plus randomized traffic
// against an expected-byte queue and a simple UART busy model.
// Second instance covers the MS-first, 4-byte configuration.
module tb_tx_resp_sequencer;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_data_valid = 1'b0;
  logic        busy;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;
  logic [2:0]  q_count;
  logic        drop_err;

  logic [31:0] alu4 = '0;
  logic        alu4_vld = 1'b0;
  logic [7:0]  rd4 = '0;
  logic        rd4_vld = 1'b0;
  logic        busy4 = 1'b0;
  logic [7:0]  tx4_dat;
  logic        tx4_vld;
  logic [2:0]  qc4;
  logic        drop4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] got4[$];

  int   pending = 0;
  int   n_tx = 0;
  int   n_drop = 0;
  int   qc_peak = 0;
  int   busy_len = 10;
  bit   rand_busy = 1'b0;
  int   uart_cnt = 0;
  int   cnt4 = 0;
  logic uart_busy = 1'b0;
  logic force_busy = 1'b0;
  logic cur_drop = 1'b0;
  logic drop_prev = 1'b0;
  logic [7:0] last_tx = '0;

  assign busy = uart_busy | force_busy;

  always #5 clk = ~clk;

  tx_resp_sequencer #(
    .DATA_WIDTH(8), .ALU_BYTES(2), .QUEUE_DEPTH(QD), .LSB_FIRST(1)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy),
    .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld),
    .q_count(q_count), .drop_err(drop_err)
  );

  tx_resp_sequencer #(
    .DATA_WIDTH(8), .ALU_BYTES(4), .QUEUE_DEPTH(4), .LSB_FIRST(0)
  ) dut4 (
    .clk(clk), .rst(rst),
    .alu_out(alu4), .alu_out_valid(alu4_vld),
    .rd_data(rd4), .rd_data_valid(rd4_vld),
    .busy(busy4),
    .tx_p_data(tx4_dat), .tx_d_vld(tx4_vld),
    .q_count(qc4), .drop_err(drop4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected byte order for a 2-byte, LS-first ALU entry.
  task automatic exp_alu(input logic [15:0] v);
    exp_q.push_back('{b: v[7:0], first: 1'b1});
    exp_q.push_back('{b: v[15:8], first: 1'b0});
    pending++;
  endtask

  task automatic exp_reg(input logic [7:0] v);
    exp_q.push_back('{b: v, first: 1'b1});
    pending++;
  endtask

  // One strobe cycle; accept=0 marks an entry the queue must discard.
  task automatic strobe(input logic av, input logic rv, input logic [15:0] a,
                        input logic [7:0] r, input bit accept);
    alu_out       = a;
    rd_data       = r;
    alu_out_valid = av;
    rd_data_valid = rv;
    cur_drop      = (av && rv) || ((av || rv) && !accept);
    if (accept) begin
      if (av) exp_alu(a);
      else if (rv) exp_reg(r);
    end
    tick(1);
    alu_out_valid = 1'b0;
    rd_data_valid = 1'b0;
    cur_drop      = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || uart_cnt != 0) && c < maxc) begin
      tick(1);
      c++;
    end
    tick(3);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Main monitor + UART model: busy rises the cycle after each tx_d_vld.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      uart_cnt  = 0;
      uart_busy = 1'b0;
      drop_prev = 1'b0;
      last_tx   = '0;
    end else begin
      if (tx_d_vld) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", 32'(tx_d_vld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(tx_p_data), 32'(e.b));
          if (e.first) pending--;
        end
        last_tx  = tx_p_data;
        uart_cnt = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
      end else begin
        chk("tx_hold", 32'(tx_p_data), 32'(last_tx));
        if (uart_cnt > 0) uart_cnt--;
      end
      uart_busy = (uart_cnt > 0);
      chk("drop_err", 32'(drop_err), 32'(drop_prev));
      drop_prev = cur_drop;
      if (drop_err) n_drop++;
      if (int'(q_count) > qc_peak) qc_peak = int'(q_count);
    end
  end

  // Collector + UART model for the MS-first instance.
  always @(negedge clk) begin
    if (!rst) begin
      cnt4  = 0;
      busy4 = 1'b0;
    end else begin
      if (tx4_vld) begin
        got4.push_back(tx4_dat);
        cnt4 = 5;
      end else if (cnt4 > 0) begin
        cnt4--;
      end
      busy4 = (cnt4 > 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int d0;
    int c;
    int k;
    logic [7:0] exp4 [5];

    // Reset values
    #3 rst = 1'b0;
    #4;
    chk("rst_tx_d_vld", 32'(tx_d_vld), 32'd0);
    chk("rst_tx_p_data", 32'(tx_p_data), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Latency: strobe in cycle 0 -> tx_d_vld in cycle 3
    strobe(1'b0, 1'b1, 16'h0, 8'h11, 1'b1);
    chk("lat_qcount_c1", 32'(q_count), 32'd1);
    tick(1);
    chk("lat_vld_c2", 32'(tx_d_vld), 32'd0);
    tick(1);
    chk("lat_vld_c3", 32'(tx_d_vld), 32'd1);
    chk("lat_dat_c3", 32'(tx_p_data), 32'h11);
    drain(100);

    // Two-byte ALU result, LS byte first
    n0 = n_tx;
    strobe(1'b1, 1'b0, 16'hA55A, 8'h0, 1'b1);
    drain(200);
    chk("a55a_pulses", 32'(n_tx - n0), 32'd2);

    // Register byte held off by a long busy
    force_busy = 1'b1;
    n0 = n_tx;
    strobe(1'b0, 1'b1, 16'h0, 8'h3C, 1'b1);
    tick(20);
    chk("busy_hold_pulses", 32'(n_tx - n0), 32'd0);
    force_busy = 1'b0;
    drain(200);
    chk("3c_pulses", 32'(n_tx - n0), 32'd1);

    // Dual strobe: ALU kept, register byte dropped
    qc_peak = 0;
    d0 = n_drop;
    n0 = n_tx;
    strobe(1'b1, 1'b1, 16'h1234, 8'hFF, 1'b1);
    drain(200);
    chk("dual_drops", 32'(n_drop - d0), 32'd1);
    chk("dual_pulses", 32'(n_tx - n0), 32'd2);
    chk("dual_qc_peak", 32'(qc_peak), 32'd1);

    // Overflow: six back-to-back register strobes while busy
    force_busy = 1'b1;
    qc_peak = 0;
    d0 = n_drop;
    n0 = n_tx;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b0, 1'b1, 16'h0, 8'(8'h40 + i), (i < 5));
    end
    tick(3);
    chk("ovf_qc_peak", 32'(qc_peak), 32'd4);
    chk("ovf_q_count", 32'(q_count), 32'd4);
    chk("ovf_drops", 32'(n_drop - d0), 32'd1);
    force_busy = 1'b0;
    drain(500);
    chk("ovf_pulses", 32'(n_tx - n0), 32'd5);

    // MS-first, 4-byte instance: ALU entry then a register byte
    alu4 = 32'h01020304;
    alu4_vld = 1'b1;
    tick(1);
    alu4_vld = 1'b0;
    rd4 = 8'h77;
    rd4_vld = 1'b1;
    tick(1);
    rd4_vld = 1'b0;
    c = 0;
    while (got4.size() < 5 && c < 300) begin
      tick(1);
      c++;
    end
    tick(10);
    chk("msb_count", 32'(got4.size()), 32'd5);
    exp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h77};
    for (int i = 0; i < 5; i++) begin
      if (i < got4.size()) chk("msb_byte", 32'(got4[i]), 32'(exp4[i]));
    end

    // Reset right after the first byte of 16'hBEEF
    busy_len = 10;
    strobe(1'b1, 1'b0, 16'hBEEF, 8'h0, 1'b1);
    c = 0;
    while (!tx_d_vld && c < 20) begin
      tick(1);
      c++;
    end
    chk("beef_first_vld", 32'(tx_d_vld), 32'd1);
    chk("beef_first_dat", 32'(tx_p_data), 32'hEF);
    rst = 1'b0;
    #1;
    chk("midrst_vld", 32'(tx_d_vld), 32'd0);
    chk("midrst_dat", 32'(tx_p_data), 32'd0);
    chk("midrst_qcount", 32'(q_count), 32'd0);
    exp_q.delete();
    pending = 0;
    tick(2);
    rst = 1'b1;
    n0 = n_tx;
    tick(60);
    chk("postrst_pulses", 32'(n_tx - n0), 32'd0);
    chk("postrst_qcount", 32'(q_count), 32'd0);

    // Randomized traffic; strobes are held back so the queue never overflows
    rand_busy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (pending < QD && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 3));
        strobe((k != 2), (k >= 2), 16'($urandom), 8'($urandom), 1'b1);
      end else begin
        tick(1);
      end
    end
    drain(3000);
    chk("rand_qcount_end", 32'(q_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
